cnn_layer_accel_octo_load_sched: RTL and testbench

Load scheduler for `cnn_layer_accel_octo`. On `start` it pulses `new_map`, then streams the sequence table and then the pixel map from two upstream valid/ready sources onto the octo's shared `datain` bus. It drives the matching `seq_datain_tag` / `pixel_datain_tag` and honours the octo's per-tag ready signals. It replaces bench-driven loading and sits between the input DMA FIFOs and the octo.

---
 rtl/cnn_layer_accel_octo_load_sched.sv | 218 +++++++++++++++++++++
 tb/tb_cnn_layer_accel_octo_load_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_octo_load_sched.sv
// Load scheduler for cnn_layer_accel_octo.
// On start it pulses new_map, streams the sequence table and then the pixel
// map from two valid/ready sources onto the octo's shared datain bus. It drives
// the matching bus-owner tag and honours the octo's per-tag ready.
module cnn_layer_accel_octo_load_sched #(
  parameter int C_PIXEL_WIDTH    = 16,
  parameter int C_SEQ_DATA_WIDTH = 13,
  parameter int C_DIM_WIDTH      = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [C_DIM_WIDTH-1:0]      num_input_rows_cfg,
  input  logic [C_DIM_WIDTH-1:0]      num_input_cols_cfg,
  input  logic [C_DIM_WIDTH-1:0]      kernel_size_cfg,
  input  logic [C_SEQ_DATA_WIDTH-1:0] seq_src_data,
  input  logic                        seq_src_valid,
  output logic                        seq_src_rdy,
  input  logic [C_PIXEL_WIDTH-1:0]    pix_src_data,
  input  logic                        pix_src_valid,
  output logic                        pix_src_rdy,
  output logic                        new_map,
  output logic [C_PIXEL_WIDTH-1:0]    datain,
  output logic                        datain_valid,
  output logic                        seq_datain_tag,
  output logic                        pixel_datain_tag,
  input  logic                        seq_datain_rdy,
  input  logic                        pixel_datain_rdy,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err
);

  localparam int CW = 2 * C_DIM_WIDTH;
  localparam int DW = C_DIM_WIDTH + 1;
  localparam int PW = 2 * C_DIM_WIDTH + 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NEWMAP = 3'd1,
    ST_SEQ    = 3'd2,
    ST_GAP    = 3'd3,
    ST_PIX    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [12:0]             seq_cnt_q, seq_cnt_d;
  logic [CW-1:0]           pix_cnt_q, pix_cnt_d;
  logic [CW-1:0]           fetched_q, fetched_d;
  logic [CW-1:0]           sent_q, sent_d;
  logic [C_PIXEL_WIDTH-1:0] datain_q, datain_d;
  logic                    datain_valid_q, datain_valid_d;
  logic                    new_map_q, new_map_d;
  logic                    seq_tag_q, seq_tag_d;
  logic                    pix_tag_q, pix_tag_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    cfg_err_q, cfg_err_d;

  logic [DW-1:0]            cols_s, rows_s, k_s, diff_s;
  logic [31:0]              seq_full_s;
  logic [PW-1:0]            pix_full_s;
  logic                     cfg_bad_s;
  logic [CW-1:0]            cur_cnt_s;
  logic                     in_seq_s, in_pix_s;
  logic                     xfer_s, room_s, below_s;
  logic                     seq_fetch_s, pix_fetch_s, fetch_s;
  logic [C_PIXEL_WIDTH-1:0] seq_ext_s, src_word_s;

  // Config arithmetic: dimensions, phase word counts and legality check.
  always_comb begin
    cols_s     = {1'b0, num_input_cols_cfg} + DW'(1);
    rows_s     = {1'b0, num_input_rows_cfg} + DW'(1);
    k_s        = {1'b0, kernel_size_cfg};
    diff_s     = cols_s - k_s + DW'(1);
    seq_full_s = 32'(diff_s) * 32'd5;
    pix_full_s = PW'(rows_s) * PW'(cols_s);
    cfg_bad_s  = (k_s == DW'(0)) | (k_s > cols_s) | (k_s > rows_s);
  end

  // Handshake decode: octo transfer, room in the output register, source fetch.
  always_comb begin
    in_seq_s  = (state_q == ST_SEQ);
    in_pix_s  = (state_q == ST_PIX);
    cur_cnt_s = in_seq_s ? CW'(seq_cnt_q) : pix_cnt_q;
    xfer_s    = datain_valid_q & ((in_seq_s & seq_tag_q & seq_datain_rdy) |
                                  (in_pix_s & pix_tag_q & pixel_datain_rdy));
    room_s    = ~datain_valid_q | xfer_s;
    below_s   = (fetched_q < cur_cnt_s);
    seq_src_rdy = in_seq_s & below_s & room_s;
    pix_src_rdy = in_pix_s & below_s & room_s;
    seq_fetch_s = seq_src_valid & seq_src_rdy;
    pix_fetch_s = pix_src_valid & pix_src_rdy;
    fetch_s     = seq_fetch_s | pix_fetch_s;
    seq_ext_s   = '0;
    seq_ext_s[C_SEQ_DATA_WIDTH-1:0] = seq_src_data;
    src_word_s  = in_seq_s ? seq_ext_s : pix_src_data;
  end

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d        = state_q;
    seq_cnt_d      = seq_cnt_q;
    pix_cnt_d      = pix_cnt_q;
    fetched_d      = fetched_q;
    sent_d         = sent_q;
    datain_d       = datain_q;
    datain_valid_d = datain_valid_q;
    cfg_err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        fetched_d = '0;
        sent_d    = '0;
        if (start) begin
          if (cfg_bad_s) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d   = ST_NEWMAP;
            seq_cnt_d = seq_full_s[12:0];
            pix_cnt_d = pix_full_s[CW-1:0];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_NEWMAP: begin
        fetched_d = '0;
        sent_d    = '0;
        state_d   = ST_SEQ;
      end
      ST_SEQ, ST_PIX: begin
        fetched_d = fetched_q + CW'(fetch_s);
        sent_d    = sent_q + CW'(xfer_s);
        if (xfer_s && ((sent_q + CW'(1)) == cur_cnt_s)) begin
          state_d = in_seq_s ? ST_GAP : ST_DONE;
        end else begin
          state_d = state_q;
        end
      end
      ST_GAP: begin
        fetched_d = '0;
        sent_d    = '0;
        state_d   = ST_PIX;
      end
      ST_DONE: begin
        fetched_d = '0;
        sent_d    = '0;
        state_d   = ST_IDLE;
      end
      default: begin
        fetched_d = '0;
        sent_d    = '0;
        state_d   = ST_IDLE;
      end
    endcase

    // A fetch always lands in the register; a lone transfer empties it.
    if (fetch_s) begin
      datain_d       = src_word_s;
      datain_valid_d = 1'b1;
    end else if (xfer_s) begin
      datain_valid_d = 1'b0;
    end else begin
      datain_valid_d = datain_valid_q;
    end

    new_map_d = (state_d == ST_NEWMAP);
    seq_tag_d = (state_d == ST_SEQ);
    pix_tag_d = (state_d == ST_PIX);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      seq_cnt_q      <= '0;
      pix_cnt_q      <= '0;
      fetched_q      <= '0;
      sent_q         <= '0;
      datain_q       <= '0;
      datain_valid_q <= 1'b0;
      new_map_q      <= 1'b0;
      seq_tag_q      <= 1'b0;
      pix_tag_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      seq_cnt_q      <= seq_cnt_d;
      pix_cnt_q      <= pix_cnt_d;
      fetched_q      <= fetched_d;
      sent_q         <= sent_d;
      datain_q       <= datain_d;
      datain_valid_q <= datain_valid_d;
      new_map_q      <= new_map_d;
      seq_tag_q      <= seq_tag_d;
      pix_tag_q      <= pix_tag_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

  assign new_map          = new_map_q;
  assign datain           = datain_q;
  assign datain_valid     = datain_valid_q;
  assign seq_datain_tag   = seq_tag_q;
  assign pixel_datain_tag = pix_tag_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_cnn_layer_accel_octo_load_sched.sv
// Self-checking bench for cnn_layer_accel_octo_load_sched.
// Source handshakes push the expected bus word into a scoreboard queue; octo
// transfers pop and compare it. Inputs are driven on the falling edge.
module tb_cnn_layer_accel_octo_load_sched;
  localparam int PW = 16;
  localparam int SW = 13;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [DW-1:0] rows_cfg, cols_cfg, k_cfg;
  logic [SW-1:0] seq_src_data;
  logic          seq_src_valid, seq_src_rdy;
  logic [PW-1:0] pix_src_data;
  logic          pix_src_valid, pix_src_rdy;
  logic          new_map, datain_valid, seq_datain_tag, pixel_datain_tag;
  logic [PW-1:0] datain;
  logic          seq_datain_rdy, pixel_datain_rdy;
  logic          busy, done, cfg_err;

  always #5 clk = ~clk;

  cnn_layer_accel_octo_load_sched #(
    .C_PIXEL_WIDTH(PW), .C_SEQ_DATA_WIDTH(SW), .C_DIM_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .num_input_rows_cfg(rows_cfg), .num_input_cols_cfg(cols_cfg),
    .kernel_size_cfg(k_cfg),
    .seq_src_data(seq_src_data), .seq_src_valid(seq_src_valid), .seq_src_rdy(seq_src_rdy),
    .pix_src_data(pix_src_data), .pix_src_valid(pix_src_valid), .pix_src_rdy(pix_src_rdy),
    .new_map(new_map), .datain(datain), .datain_valid(datain_valid),
    .seq_datain_tag(seq_datain_tag), .pixel_datain_tag(pixel_datain_tag),
    .seq_datain_rdy(seq_datain_rdy), .pixel_datain_rdy(pixel_datain_rdy),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  int compared = 0;
  int mismatched = 0;

  logic [17:0]   exp_q[$];
  logic [SW-1:0] seq_src[$];
  logic [PW-1:0] pix_src[$];

  int seq_vp, pix_vp, rdy_p;
  int cyc, seq_fetch, pix_fetch, seq_sent, pix_sent;
  int done_cnt, done_cyc, nm_cnt, nm_cyc, cfg_cnt, gap_cnt, overlap_cnt;
  int first_xfer_cyc, last_seq_cyc, stall_at, stall_left;
  bit seq_hold, pix_hold, start_req, rst_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    seq_fetch = 0; pix_fetch = 0; seq_sent = 0; pix_sent = 0;
    done_cnt = 0; done_cyc = -1; nm_cnt = 0; nm_cyc = -1; cfg_cnt = 0;
    gap_cnt = 0; overlap_cnt = 0; first_xfer_cyc = -1; last_seq_cyc = -1;
    seq_hold = 0; pix_hold = 0; stall_left = 0; stall_at = -1;
  endtask

  // One clock cycle: drive on the falling edge, observe 1 time unit later.
  task automatic step();
    logic        xs, xp;
    logic [17:0] e;
    @(negedge clk);
    start = start_req;
    rst   = rst_req;
    if (!seq_hold) seq_src_valid = (seq_src.size() > 0) && ($urandom_range(99) < seq_vp);
    seq_src_data = (seq_src.size() > 0) ? seq_src[0] : '0;
    if (!pix_hold) pix_src_valid = (pix_src.size() > 0) && ($urandom_range(99) < pix_vp);
    pix_src_data = (pix_src.size() > 0) ? pix_src[0] : '0;
    seq_datain_rdy = ($urandom_range(99) < rdy_p);
    if (stall_left > 0 && pix_sent == stall_at && datain_valid && pixel_datain_tag) begin
      pixel_datain_rdy = 1'b0;
      stall_left--;
      chk("stall_valid", 32'(datain_valid), 32'd1);
      if (exp_q.size() > 0) chk("stall_hold", 32'(datain), 32'(exp_q[0][15:0]));
      else chk("stall_queue", 32'(exp_q.size()), 32'd1);
    end else begin
      pixel_datain_rdy = ($urandom_range(99) < rdy_p);
    end
    #1;
    xs = datain_valid && seq_datain_tag && seq_datain_rdy;
    xp = datain_valid && pixel_datain_tag && pixel_datain_rdy;
    if (xs || xp) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("word", 32'({seq_datain_tag, pixel_datain_tag, datain}), 32'(e));
      end else begin
        chk("extra_word", 32'(exp_q.size()), 32'd1);
      end
      if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
      if (xs) begin seq_sent++; last_seq_cyc = cyc; end
      if (xp) pix_sent++;
    end
    if (seq_src_valid && seq_src_rdy) begin
      exp_q.push_back({2'b10, 3'b000, seq_src[0]});
      void'(seq_src.pop_front());
      seq_fetch++;
      seq_hold = 0;
    end else begin
      seq_hold = seq_src_valid;
    end
    if (pix_src_valid && pix_src_rdy) begin
      exp_q.push_back({2'b01, pix_src[0]});
      void'(pix_src.pop_front());
      pix_fetch++;
      pix_hold = 0;
    end else begin
      pix_hold = pix_src_valid;
    end
    if (seq_datain_tag && pixel_datain_tag) overlap_cnt++;
    if (busy && !seq_datain_tag && !pixel_datain_tag && !new_map && !done) gap_cnt++;
    if (new_map) begin nm_cnt++; nm_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (cfg_err) cfg_cnt++;
    cyc++;
  endtask

  task automatic check_reset_outs(input string tag);
    chk(tag, 32'({new_map, datain_valid, seq_datain_tag, pixel_datain_tag,
                  seq_src_rdy, pix_src_rdy, busy, done, cfg_err}), 32'd0);
    chk({tag, "_datain"}, 32'(datain), 32'd0);
  endtask

  // Full 10x10, K=3 load; optional octo stall, mid-load reset, or busy start.
  task automatic run_load(input int svp, input int pvp, input int rp, input int st_at,
                          input int rst_at, input int exp_done, input int busy_start_at);
    bit rst_fired;
    rst_fired = 0;
    clear_stats();
    exp_q.delete(); seq_src.delete(); pix_src.delete();
    for (int i = 0; i < 43; i++) seq_src.push_back(SW'($urandom));
    for (int i = 0; i < 103; i++) pix_src.push_back(PW'($urandom));
    seq_vp = svp; pix_vp = pvp; rdy_p = rp;
    stall_at = st_at; stall_left = (st_at >= 0) ? 5 : 0;
    rows_cfg = 10'd9; cols_cfg = 10'd9; k_cfg = 10'd3;
    cyc = 0;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    while (done_cnt == 0 && cyc < 3000 && !rst_fired) begin
      if (busy_start_at >= 0 && cyc == busy_start_at) start_req = 1'b1;
      if (rst_at >= 0 && pix_sent == rst_at) begin rst_req = 1'b1; rst_fired = 1; end
      step();
      start_req = 1'b0;
      rst_req = 1'b0;
    end
    if (rst_fired) begin
      step();
      check_reset_outs("midload_rst");
      repeat (4) step();
      chk("rst_no_done", 32'(done_cnt), 32'd0);
      chk("rst_idle_busy", 32'(busy), 32'd0);
    end else begin
      chk("done_seen", 32'(done_cnt), 32'd1);
      repeat (8) step();
      chk("done_once", 32'(done_cnt), 32'd1);
      chk("newmap_once", 32'(nm_cnt), 32'd1);
      chk("newmap_cyc", 32'(nm_cyc), 32'd1);
      if (exp_done >= 0) begin
        chk("done_cyc", 32'(done_cyc), 32'(exp_done));
        chk("first_xfer_cyc", 32'(first_xfer_cyc), 32'd3);
        chk("last_seq_cyc", 32'(last_seq_cyc), 32'd42);
      end
      chk("seq_fetched", 32'(seq_fetch), 32'd40);
      chk("pix_fetched", 32'(pix_fetch), 32'd100);
      chk("seq_sent", 32'(seq_sent), 32'd40);
      chk("pix_sent", 32'(pix_sent), 32'd100);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      chk("seq_extra_left", 32'(seq_src.size()), 32'd3);
      chk("pix_extra_left", 32'(pix_src.size()), 32'd3);
      chk("tag_overlap", 32'(overlap_cnt), 32'd0);
      chk("gap_cycles", 32'(gap_cnt), 32'd1);
      chk("idle_after", 32'({busy, datain_valid, seq_src_rdy, pix_src_rdy}), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    rows_cfg = '0; cols_cfg = '0; k_cfg = '0;
    seq_src_data = '0; seq_src_valid = 1'b0; pix_src_data = '0; pix_src_valid = 1'b0;
    seq_datain_rdy = 1'b0; pixel_datain_rdy = 1'b0;
    start_req = 1'b0; rst_req = 1'b1;
    seq_vp = 0; pix_vp = 0; rdy_p = 100; cyc = 0;
    clear_stats();

    // Reset state.
    repeat (3) step();
    rst_req = 1'b0;
    step();
    check_reset_outs("reset_state");

    // Full-rate load: done at 2+40+1+1+100+1 = 145; start at cycle 50 is ignored.
    run_load(100, 100, 100, -1, -1, 145, 50);

    // Octo stall of 5 cycles at pixel 43 pushes done 5 cycles later.
    run_load(100, 100, 100, 43, -1, 150, -1);

    // Random source bubbles and octo ready.
    run_load(50, 50, 70, -1, -1, -1, -1);

    // Reset at pixel 20, then a clean reload from sequence word 0.
    run_load(100, 100, 100, -1, 20, -1, -1);
    run_load(100, 100, 100, -1, -1, 145, -1);

    // Rejected config: cols=2, K=3.
    clear_stats();
    seq_src.delete(); pix_src.delete();
    seq_src_valid = 1'b0; pix_src_valid = 1'b0;
    rows_cfg = 10'd9; cols_cfg = 10'd1; k_cfg = 10'd3;
    cyc = 0;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    step();
    chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
    chk("cfg_err_no_newmap", 32'(new_map), 32'd0);
    chk("cfg_err_busy", 32'(busy), 32'd0);
    step();
    chk("cfg_err_clear", 32'(cfg_err), 32'd0);
    repeat (4) step();
    chk("cfg_err_nm_cnt", 32'(nm_cnt), 32'd0);
    chk("cfg_err_cnt", 32'(cfg_cnt), 32'd1);
    chk("cfg_err_idle", 32'(busy), 32'd0);

    // Rejected config: K=0.
    clear_stats();
    cols_cfg = 10'd9; k_cfg = 10'd0;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    step();
    chk("k0_cfg_err", 32'(cfg_err), 32'd1);
    repeat (3) step();
    chk("k0_nm_cnt", 32'(nm_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
